ppp_bank_sched: RTL and testbench

//  Ping-pong bank scheduler for the ppp_top buffer between the ISP writer and the DLA reader.

---
 rtl/ppp_bank_sched.sv | 134 +++++++++++++
 tb/tb_ppp_bank_sched.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/ppp_bank_sched.sv
// ppp_bank_sched: ping-pong bank scheduler between the ISP writer and the DLA reader.
// Hands out strips of STRIP_ROWS rows over rdy/resp/done handshakes and counts drained strips.
module ppp_bank_sched #(
    parameter int IMGH_WIDTH = 11,
    parameter int STRIP_ROWS = 32,
    parameter int CNT_WIDTH  = 11
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  top_start_i,
    input  logic [IMGH_WIDTH-1:0] img_height_i,
    output logic                  isp_rdy_o,
    input  logic                  isp_resp_i,
    input  logic                  isp_done_i,
    output logic                  isp_wbank_o,
    output logic                  dla_rdy_o,
    input  logic                  dla_resp_i,
    input  logic                  dla_done_i,
    output logic                  dla_rbank_o,
    output logic [CNT_WIDTH-1:0]  strip_cnt_o,
    output logic                  busy_o,
    output logic                  frame_done_o,
    output logic                  err_o
);
    localparam int SHIFT = $clog2(STRIP_ROWS);

    typedef enum logic {IDLE, RUN} top_t;
    typedef enum logic [1:0] {EMPTY, FILLING, FULL, DRAINING} bank_t;

    top_t                 st, st_nxt;
    bank_t                bank [2];
    bank_t                bank_nxt [2];
    logic                 wptr, wptr_nxt, rptr, rptr_nxt;
    logic [CNT_WIDTH-1:0] total, total_nxt, issued, issued_nxt, strips, strips_nxt;
    logic                 isp_rdy_nxt, dla_rdy_nxt, done_nxt, err_nxt;
    logic [IMGH_WIDTH:0]  rows_up;

    assign isp_wbank_o = wptr;
    assign dla_rbank_o = rptr;
    assign strip_cnt_o = strips;
    assign busy_o      = (st == RUN);

    always_comb begin
        st_nxt     = st;
        bank_nxt   = bank;
        wptr_nxt   = wptr;
        rptr_nxt   = rptr;
        total_nxt  = total;
        issued_nxt = issued;
        strips_nxt = strips;
        done_nxt   = 1'b0;
        err_nxt    = err_o;
        rows_up    = {1'b0, img_height_i} + (IMGH_WIDTH+1)'(STRIP_ROWS - 1);
        if (st == IDLE) begin
            if (top_start_i) begin
                total_nxt  = CNT_WIDTH'(rows_up >> SHIFT);
                issued_nxt = '0;
                strips_nxt = '0;
                if (total_nxt == '0)
                    done_nxt = 1'b1;
                else
                    st_nxt = RUN;
            end
            if (isp_resp_i || isp_done_i || dla_resp_i || dla_done_i)
                err_nxt = 1'b1;
        end else begin
            if (strips == total)
                st_nxt = IDLE;
            if (isp_resp_i) begin
                if (isp_rdy_o) begin
                    bank_nxt[wptr] = FILLING;
                    issued_nxt     = issued + 1'b1;
                end else
                    err_nxt = 1'b1;
            end
            if (isp_done_i) begin
                if (bank[wptr] == FILLING) begin
                    bank_nxt[wptr] = FULL;
                    wptr_nxt       = ~wptr;
                end else
                    err_nxt = 1'b1;
            end
            if (dla_resp_i) begin
                if (dla_rdy_o)
                    bank_nxt[rptr] = DRAINING;
                else
                    err_nxt = 1'b1;
            end
            if (dla_done_i) begin
                if (bank[rptr] == DRAINING) begin
                    bank_nxt[rptr] = EMPTY;
                    rptr_nxt       = ~rptr;
                    strips_nxt     = strips + 1'b1;
                    done_nxt       = (strips_nxt == total);
                end else
                    err_nxt = 1'b1;
            end
        end
        // Offers are registered from next state, so a freed bank is offered the very next cycle.
        isp_rdy_nxt = (st_nxt == RUN) && (bank_nxt[wptr_nxt] == EMPTY) &&
                      (bank_nxt[0] != FILLING) && (bank_nxt[1] != FILLING) &&
                      (issued_nxt < total_nxt);
        dla_rdy_nxt = (st_nxt == RUN) && (bank_nxt[rptr_nxt] == FULL) &&
                      (bank_nxt[0] != DRAINING) && (bank_nxt[1] != DRAINING);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            st           <= IDLE;
            bank         <= '{EMPTY, EMPTY};
            wptr         <= 1'b0;
            rptr         <= 1'b0;
            total        <= '0;
            issued       <= '0;
            strips       <= '0;
            isp_rdy_o    <= 1'b0;
            dla_rdy_o    <= 1'b0;
            frame_done_o <= 1'b0;
            err_o        <= 1'b0;
        end else begin
            st           <= st_nxt;
            bank         <= bank_nxt;
            wptr         <= wptr_nxt;
            rptr         <= rptr_nxt;
            total        <= total_nxt;
            issued       <= issued_nxt;
            strips       <= strips_nxt;
            isp_rdy_o    <= isp_rdy_nxt;
            dla_rdy_o    <= dla_rdy_nxt;
            frame_done_o <= done_nxt;
            err_o        <= err_nxt;
        end
    end
endmodule

// File: tb/tb_ppp_bank_sched.sv
// tb_ppp_bank_sched: directed checks of the ping-pong bank scheduler.
module tb_ppp_bank_sched;
    localparam logic [3:0] IR = 4'b1000, ID = 4'b0100, DR = 4'b0010, DD = 4'b0001;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        top_start = 1'b0;
    logic [10:0] img_height = '0;
    logic        isp_rdy, isp_resp = 1'b0, isp_done = 1'b0, isp_wbank;
    logic        dla_rdy, dla_resp = 1'b0, dla_done = 1'b0, dla_rbank;
    logic [10:0] strip_cnt;
    logic        busy, frame_done, err;
    int          passed = 0, checks = 0;

    ppp_bank_sched dut (
        .clk(clk), .rst_n(rst_n), .top_start_i(top_start), .img_height_i(img_height),
        .isp_rdy_o(isp_rdy), .isp_resp_i(isp_resp), .isp_done_i(isp_done), .isp_wbank_o(isp_wbank),
        .dla_rdy_o(dla_rdy), .dla_resp_i(dla_resp), .dla_done_i(dla_done), .dla_rbank_o(dla_rbank),
        .strip_cnt_o(strip_cnt), .busy_o(busy), .frame_done_o(frame_done), .err_o(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) passed++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic [3:0] m);
        {isp_resp, isp_done, dla_resp, dla_done} = m;
        step();
        {isp_resp, isp_done, dla_resp, dla_done} = 4'b0;
    endtask

    task automatic start(input logic [10:0] h);
        img_height = h;
        top_start  = 1'b1;
        step();
        top_start  = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    function automatic logic [31:0] outs();
        return 32'({isp_rdy, isp_wbank, dla_rdy, dla_rbank, busy, frame_done, err, strip_cnt});
    endfunction

    initial begin
        do_reset();
        chk("reset_outs", outs(), 0);

        // one strip
        start(11'd32);
        chk("t1_busy", 32'(busy), 1);
        chk("t1_isp_rdy", 32'(isp_rdy), 1);
        pulse(IR);
        chk("t1_isp_rdy_drop", 32'(isp_rdy), 0);
        pulse(ID);
        chk("t1_dla_rdy", 32'({dla_rdy, dla_rbank, isp_rdy}), 3'b100);
        pulse(DR);
        chk("t1_dla_rdy_drop", 32'(dla_rdy), 0);
        pulse(DD);
        chk("t1_done", 32'({frame_done, busy}), 2'b11);
        chk("t1_cnt", 32'(strip_cnt), 1);
        step();
        chk("t1_idle", 32'({frame_done, busy, err}), 0);
        chk("t1_cnt_hold", 32'(strip_cnt), 1);

        // overlapped two-strip frame
        do_reset();
        start(11'd64);
        pulse(IR);
        pulse(ID);
        chk("t2_offer", 32'({isp_rdy, isp_wbank, dla_rdy, dla_rbank}), 4'b1110);
        pulse(IR | DR);
        chk("t2_both_held", 32'({isp_rdy, dla_rdy}), 0);
        pulse(ID | DD);
        chk("t2_swap", 32'({isp_rdy, isp_wbank, dla_rdy, dla_rbank, frame_done}), 5'b00110);
        chk("t2_cnt1", 32'(strip_cnt), 1);
        pulse(DR);
        pulse(DD);
        chk("t2_done", 32'({frame_done, strip_cnt}), {1'b1, 11'd2});
        step();
        chk("t2_busy_clr", 32'(busy), 0);

        // DLA stall blocks reuse
        do_reset();
        start(11'd96);
        pulse(IR);
        pulse(ID);
        pulse(IR);
        pulse(ID);
        chk("t3_stall", 32'({isp_rdy, dla_rdy}), 2'b01);
        step();
        step();
        chk("t3_stall_hold", 32'(isp_rdy), 0);
        pulse(DR);
        chk("t3_draining", 32'(isp_rdy), 0);
        pulse(DD);
        chk("t3_reuse", 32'({isp_rdy, isp_wbank, dla_rdy, dla_rbank}), 4'b1011);
        chk("t3_cnt1", 32'(strip_cnt), 1);
        pulse(IR);
        pulse(ID);
        pulse(DR);
        pulse(DD);
        chk("t3_cnt2", 32'({frame_done, strip_cnt}), {1'b0, 11'd2});
        pulse(DR);
        pulse(DD);
        chk("t3_done", 32'({frame_done, strip_cnt}), {1'b1, 11'd3});

        // rounding up, start while busy, empty frame
        do_reset();
        start(11'd33);
        pulse(IR);
        pulse(ID);
        pulse(DR);
        pulse(DD);
        chk("t4_mid", 32'({frame_done, busy, strip_cnt}), {2'b01, 11'd1});
        start(11'd0);
        chk("t4_ignored_start", 32'({frame_done, busy, err, strip_cnt}), {3'b010, 11'd1});
        pulse(IR);
        pulse(ID);
        pulse(DR);
        pulse(DD);
        chk("t4_done", 32'({frame_done, strip_cnt}), {1'b1, 11'd2});
        step();
        start(11'd0);
        chk("t4_zero", 32'({frame_done, busy, isp_rdy, strip_cnt}), 0 | (1 << 13));
        step();
        chk("t4_zero_end", 32'({frame_done, busy}), 0);

        // protocol faults
        do_reset();
        pulse(ID);
        chk("t5_err_idle", 32'({err, busy}), 2'b10);
        start(11'd32);
        pulse(DR);
        chk("t5_err_sticky", 32'({err, isp_rdy, dla_rdy}), 3'b110);
        pulse(IR);
        pulse(ID);
        pulse(DR);
        pulse(DD);
        chk("t5_done", 32'({frame_done, err, strip_cnt}), {2'b11, 11'd1});

        // reset mid-frame
        do_reset();
        start(11'd64);
        pulse(IR);
        pulse(ID);
        pulse(IR);
        rst_n = 1'b0;
        step();
        chk("t6_reset_outs", outs(), 0);
        rst_n = 1'b1;
        step();
        chk("t6_no_done", 32'({frame_done, busy}), 0);
        start(11'd32);
        chk("t6_offer", 32'({isp_rdy, isp_wbank}), 2'b10);
        pulse(IR);
        pulse(ID);
        pulse(DR);
        pulse(DD);
        chk("t6_done", 32'({frame_done, err, strip_cnt}), {2'b10, 11'd1});

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
